// File: rtl/sm_mul_seq.sv
// sm_mul_seq: sequential shift-and-add multiplier for sign-magnitude operands.
//
// Accepts one operand pair per valid/ready handshake. It computes the product over W
// cycles and presents it until the downstream stage takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on a_sm/b_sm is valid
//   in_ready   block can accept an operand pair (IDLE)
//   a_sm       operand A, bit W = sign, bits W-1:0 = magnitude
//   b_sm       operand B, same format
//   out_valid  prod_sm holds a finished product (DONE)
//   out_ready  downstream accepts the product
//   prod_sm    product, bit 2W = sign, bits 2W-1:0 = magnitude
//   busy       high while calculating or holding a result
module sm_mul_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   a_sm,
    input  logic [W:0]   b_sm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2*W:0] prod_sm,
    output logic         busy
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic                sign_q;
    logic [2*W-1:0]      mcand_q;
    logic [W-1:0]        mplier_q;
    logic [2*W-1:0]      acc_q;
    logic [CntW-1:0]     cnt_q;
    logic [2*W:0]        prod_q;

    logic [2*W-1:0]      acc_next;
    logic                last_iter;

    assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_iter = (state_q == StCalc) && (cnt_q == CntW'(W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (in_valid)  state_d = StCalc;
            StCalc: if (last_iter) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default:               state_d = StIdle;
        endcase
    end

    // Handshake outputs decode only the state register
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StCalc) || (state_q == StDone);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q   <= a_sm[W] ^ b_sm[W];
                        mcand_q  <= {{W{1'b0}}, a_sm[W-1:0]};
                        mplier_q <= b_sm[W-1:0];
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StCalc: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    // Capture the final result so prod_sm is stable through DONE and after.
                    // A zero magnitude always reports +0.
                    if (last_iter) begin
                        prod_q <= {sign_q && (acc_next != '0), acc_next};
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod_sm = prod_q;

endmodule

// File: tb/tb_sm_mul_seq.sv
module tb_sm_mul_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   a_sm;
    logic [W:0]   b_sm;
    logic         out_valid;
    logic         out_ready;
    logic [2*W:0] prod_sm;
    logic         busy;

    sm_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sm      (a_sm),
        .b_sm      (b_sm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_sm   (prod_sm),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [2*W:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: integer product of magnitudes, XOR of signs, zero is always +0
    function automatic logic [2*W:0] ref_mul(input logic [W:0] a, input logic [W:0] b);
        int ma, mb, p;
        logic [31:0] pv;
        ma = int'(a[W-1:0]);
        mb = int'(b[W-1:0]);
        p  = ma * mb;
        pv = p;
        return {(a[W] ^ b[W]) && (p != 0), pv[2*W-1:0]};
    endfunction

    // Monitor: every completed output transfer is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", prod_sm);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("product", int'(prod_sm), int'(e));
            end
        end
    end

    // Drive a pair; returns the cycle stamp of the accept edge. Inputs change #1 after posedge.
    task automatic send(input logic [W:0] a, input logic [W:0] b, input bit hold,
                        input bit push, input logic [2*W:0] req, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        a_sm     = a;
        b_sm     = b;
        n        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge clk);
        if (push) exp_q.push_back(req);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, k;
        int stamps[8];
        logic [W:0] ra, rb;
        logic [2*W:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_sm      = '0;
        b_sm      = '0;
        #12;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_prod", int'(prod_sm), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic multiply with latency measurement
        send(5'b00011, 5'b10101, 1'b0, 1'b1, 9'h10F, t);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 20);
        check("latency_edges", k, W);
        check("busy_in_done", int'(busy), 1);
        drain();

        // Maximum magnitude and zero handling
        send(5'b01111, 5'b11111, 1'b0, 1'b1, 9'h1E1, t);
        drain();
        send(5'b10000, 5'b10111, 1'b0, 1'b1, 9'h000, t);
        drain();
        send(5'b00000, 5'b01001, 1'b0, 1'b1, 9'h000, t);
        drain();

        // Backpressure: result held for 10 cycles while inputs wiggle
        out_ready = 1'b0;
        held = ref_mul(5'b11101, 5'b01011);
        send(5'b11101, 5'b01011, 1'b0, 1'b1, held, t);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_sm     = 5'($urandom);
            b_sm     = 5'($urandom);
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_prod", int'(prod_sm), int'(held));
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_xfer_in_ready", int'(in_ready), 1);
        check("post_xfer_out_valid", int'(out_valid), 0);
        drain();

        // Reset in the middle of a calculation discards the product
        send(5'b00111, 5'b00110, 1'b0, 1'b0, '0, t);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_prod", int'(prod_sm), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(5'b00010, 5'b10010, 1'b0, 1'b1, 9'h104, t);
        drain();

        // Back-to-back random stream, in_valid held high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 5'($urandom);
            rb = 5'($urandom);
            send(ra, rb, 1'b1, 1'b1, ref_mul(ra, rb), stamps[i]);
        end
        in_valid = 1'b0;
        drain();
        // Consecutive accepts have W+1 non-accepting cycles between them
        for (int i = 1; i < 8; i++) begin
            check("accept_spacing", stamps[i] - stamps[i-1], W + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
